cg_rvarch_decode_stage: RTL and testbench
=========================================

CG_RVARCH_DECODE_STAGE -- requirements
Module: cg_rvarch_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter CNT_WIDTH, default 16, width of the illegal-instruction counter.
REQ-003 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  upstream instruction valid.
REQ-006 o_ready  output  1  stage can accept.
REQ-007 i_instr  input  32  raw instruction.
REQ-008 i_pc  input  XLEN  instruction address.
REQ-009 i_flush  input  1  discard the held entry and block capture.
REQ-010 o_valid  output  1  decoded entry valid.
REQ-011 i_ready  input  1  downstream accepts.
REQ-012 o_pc  output  XLEN  registered PC.
REQ-013 o_opcode, o_funct3, o_funct7  output  7/3/7  registered fields.
REQ-014 o_rd, o_rs1, o_rs2  output  5 each  registered register indices.
REQ-015 o_imm  output  XLEN  immediate, sign-extended to XLEN.
REQ-016 o_rd_we, o_is_branch, o_is_load, o_is_store, o_is_jump, o_is_word  output  1 each  class flags.
REQ-017 o_illegal  output  1  entry is an illegal instruction.
REQ-018 o_illegal_cnt  output  CNT_WIDTH  count of illegal instructions accepted.

Function
REQ-019 The stage SHALL hold at most one entry: o_ready = !o_valid || i_ready, combinational.
REQ-020 Accept SHALL occur when i_valid && o_ready && !i_flush; on accept, all decoded outputs SHALL register the decode of i_instr/i_pc, giving 1-cycle latency.
REQ-021 Transfer SHALL occur when o_valid && i_ready; with no same-cycle accept, o_valid SHALL clear.
REQ-022 Simultaneous transfer and accept SHALL load the new entry with o_valid held at 1, with no bubble.
REQ-023 With o_valid=1 and i_ready=0, every output SHALL remain stable.
REQ-024 i_flush SHALL clear o_valid next cycle, SHALL take priority over accept, and SHALL NOT increment the counter.
REQ-025 Immediate selection: I-type for LOAD, OP_IMM, OP_IMM_32 and JALR; S-type for STORE; B-type for BRANCH; J-type for JAL; U-type for LUI and AUIPC; 0 for all other opcodes.
REQ-026 U-type immediate SHALL be {instr[31:12],12'b0} sign-extended to XLEN.
REQ-027 B-type and J-type immediates SHALL have bit 0 = 0.
REQ-028 Opcodes with a destination register are LOAD, OP_IMM, AUIPC, OP, LUI, JAL, JALR, plus OP_IMM_32 and OP_32 when XLEN=64.
REQ-029 o_rd_we SHALL be 1 only for those opcodes when rd != 0 and the instruction is legal.
REQ-030 o_is_word SHALL be 1 for OP_IMM_32 and OP_32 when XLEN=64, else 0.
REQ-031 o_illegal SHALL be 1 when instr[1:0] != 2'b11.
REQ-032 o_illegal SHALL be 1 when the opcode is outside {LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM, OP_IMM_32*, OP_32*}; the starred opcodes are legal only when XLEN=64.
REQ-033 o_illegal SHALL be 1 for LOAD funct3 011/110 when XLEN=32, or funct3 111 at any XLEN.
REQ-034 o_illegal SHALL be 1 for STORE funct3 >= 100, or funct3 011 when XLEN=32.
REQ-035 o_illegal SHALL be 1 for BRANCH funct3 010/011, and for JALR funct3 != 000.
REQ-036 An illegal entry SHALL force o_rd_we, o_is_branch, o_is_load, o_is_store and o_is_jump to 0; fields and o_imm still decode.
REQ-037 o_illegal_cnt SHALL increment on each accept whose decode is illegal, and SHALL saturate at all-ones without wrap.

Reset
REQ-038 On i_rst_n low, asynchronously: o_valid=0, o_illegal_cnt=0, and all registered decode outputs=0.
REQ-039 o_ready SHALL read 1 during and after reset.
REQ-040 Reset mid-operation SHALL drop the held entry with no transfer.
REQ-041 Reset deassertion is synchronous to i_clk; the first accept is possible on the first edge after release.

Verification
REQ-042 Scenario, XLEN=32: accept 0xFFF00093 (addi x1,x0,-1) -> next cycle o_valid=1, o_rd=1, o_imm=0xFFFFFFFF, o_rd_we=1, o_illegal=0.
REQ-043 Scenario, XLEN=64: 0x123452B7 (lui x5,0x12345) -> o_imm=0x0000000012345000, o_rd=5; 0x0010009B (addiw x1,x1,1) -> o_is_word=1, o_imm=1.
REQ-044 Scenario, XLEN=32: 0x0010009B -> o_illegal=1, o_rd_we=0, o_illegal_cnt 0->1; 0x00000000 -> o_illegal=1, o_illegal_cnt=2.
REQ-045 Scenario: i_ready=0 for 3 cycles with i_valid=1 -> o_ready=0 and outputs frozen; then i_ready=1 with a new instruction -> back-to-back transfer, o_valid stays 1.
REQ-046 Scenario: i_flush with i_valid=1 and o_valid=1 -> next cycle o_valid=0 and counter unchanged; assert i_rst_n=0 mid-stream -> all outputs 0 immediately.
REQ-047 Scenario, CNT_WIDTH=2: five illegal accepts -> o_illegal_cnt stops at 3.

Source files
------------

// File: rtl/cg_rvarch_decode_stage.sv
// RV32/RV64 base-ISA decode stage: one-entry valid/ready pipeline register
// holding the decoded fields, immediate, class flags and an illegal counter.
module cg_rvarch_decode_stage #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [31:0]          i_instr,
    input  logic [XLEN-1:0]      i_pc,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [XLEN-1:0]      o_pc,
    output logic [6:0]           o_opcode,
    output logic [2:0]           o_funct3,
    output logic [6:0]           o_funct7,
    output logic [4:0]           o_rd,
    output logic [4:0]           o_rs1,
    output logic [4:0]           o_rs2,
    output logic [XLEN-1:0]      o_imm,
    output logic                 o_rd_we,
    output logic                 o_is_branch,
    output logic                 o_is_load,
    output logic                 o_is_store,
    output logic                 o_is_jump,
    output logic                 o_is_word,
    output logic                 o_illegal,
    output logic [CNT_WIDTH-1:0] o_illegal_cnt
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM  = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_OP_32     = 7'h3B;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM    = 7'h73;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            rd_we;
        logic            is_branch;
        logic            is_load;
        logic            is_store;
        logic            is_jump;
        logic            is_word;
        logic            illegal;
    } dec_t;

    logic                 accept;
    logic                 valid_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    dec_t                 dec_d;
    dec_t                 dec_q;

    logic [6:0]           opc;
    logic [2:0]           f3;
    imm_fmt_e             fmt;
    logic signed [31:0]   imm32;
    logic                 has_rd;
    logic                 cls_br;
    logic                 cls_ld;
    logic                 cls_st;
    logic                 cls_jmp;
    logic                 cls_word;
    logic                 bad;

    assign opc = i_instr[6:0];
    assign f3  = i_instr[14:12];

    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready && !i_flush;

    // Opcode classification and legality; bits [1:0] are part of opc,
    // so compressed encodings fall into the default arm.
    always_comb begin
        fmt      = IMM_NONE;
        has_rd   = 1'b0;
        cls_br   = 1'b0;
        cls_ld   = 1'b0;
        cls_st   = 1'b0;
        cls_jmp  = 1'b0;
        cls_word = 1'b0;
        bad      = 1'b0;
        case (opc)
            OPC_LOAD: begin
                fmt    = IMM_I;
                has_rd = 1'b1;
                cls_ld = 1'b1;
                bad    = (f3 == 3'b111) ||
                         (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OPC_MISC_MEM: ;
            OPC_OP_IMM: begin
                fmt    = IMM_I;
                has_rd = 1'b1;
            end
            OPC_AUIPC: begin
                fmt    = IMM_U;
                has_rd = 1'b1;
            end
            OPC_OP_IMM_32: begin
                fmt      = IMM_I;
                has_rd   = RV64;
                cls_word = RV64;
                bad      = !RV64;
            end
            OPC_STORE: begin
                fmt    = IMM_S;
                cls_st = 1'b1;
                bad    = f3[2] || (!RV64 && f3 == 3'b011);
            end
            OPC_OP: has_rd = 1'b1;
            OPC_LUI: begin
                fmt    = IMM_U;
                has_rd = 1'b1;
            end
            OPC_OP_32: begin
                has_rd   = RV64;
                cls_word = RV64;
                bad      = !RV64;
            end
            OPC_BRANCH: begin
                fmt    = IMM_B;
                cls_br = 1'b1;
                bad    = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JALR: begin
                fmt     = IMM_I;
                has_rd  = 1'b1;
                cls_jmp = 1'b1;
                bad     = (f3 != 3'b000);
            end
            OPC_JAL: begin
                fmt     = IMM_J;
                has_rd  = 1'b1;
                cls_jmp = 1'b1;
            end
            OPC_SYSTEM: ;
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        case (fmt)
            IMM_I: imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: imm32 = {{20{i_instr[31]}}, i_instr[31:25],
                            i_instr[11:7]};
            IMM_B: imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: imm32 = {i_instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{i_instr[31]}}, i_instr[31],
                            i_instr[19:12], i_instr[20],
                            i_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec_d           = '0;
        dec_d.pc        = i_pc;
        dec_d.opcode    = opc;
        dec_d.funct3    = f3;
        dec_d.funct7    = i_instr[31:25];
        dec_d.rd        = i_instr[11:7];
        dec_d.rs1       = i_instr[19:15];
        dec_d.rs2       = i_instr[24:20];
        dec_d.imm       = XLEN'(imm32);
        dec_d.rd_we     = has_rd && (i_instr[11:7] != 5'd0) && !bad;
        dec_d.is_branch = cls_br && !bad;
        dec_d.is_load   = cls_ld && !bad;
        dec_d.is_store  = cls_st && !bad;
        dec_d.is_jump   = cls_jmp && !bad;
        dec_d.is_word   = cls_word;
        dec_d.illegal   = bad;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (i_flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (i_ready) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                dec_q <= dec_d;
            end
            // Saturating: a stuck-at-max count is more useful than a wrap.
            if (accept && bad && !(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_valid       = valid_q;
    assign o_pc          = dec_q.pc;
    assign o_opcode      = dec_q.opcode;
    assign o_funct3      = dec_q.funct3;
    assign o_funct7      = dec_q.funct7;
    assign o_rd          = dec_q.rd;
    assign o_rs1         = dec_q.rs1;
    assign o_rs2         = dec_q.rs2;
    assign o_imm         = dec_q.imm;
    assign o_rd_we       = dec_q.rd_we;
    assign o_is_branch   = dec_q.is_branch;
    assign o_is_load     = dec_q.is_load;
    assign o_is_store    = dec_q.is_store;
    assign o_is_jump     = dec_q.is_jump;
    assign o_is_word     = dec_q.is_word;
    assign o_illegal     = dec_q.illegal;
    assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_cg_rvarch_decode_stage.sv
// Bench for cg_rvarch_decode_stage: RV32, RV64 and 2-bit-counter instances
// share stimulus and are compared against a reference decode model.
module tb_cg_rvarch_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vin;
    logic        flush;
    logic        rdy;
    logic [31:0] instr;
    logic [63:0] pc;

    always #5 clk = ~clk;

    logic        a_ready, a_valid, a_rd_we, a_br, a_ld, a_st, a_jmp, a_word, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [6:0]  a_opc, a_f7;
    logic [2:0]  a_f3;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [15:0] a_cnt;

    logic        b_ready, b_valid, b_rd_we, b_br, b_ld, b_st, b_jmp, b_word, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [6:0]  b_opc, b_f7;
    logic [2:0]  b_f3;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [15:0] b_cnt;

    logic        c_ready, c_valid, c_rd_we, c_br, c_ld, c_st, c_jmp, c_word, c_ill;
    logic [31:0] c_pc, c_imm;
    logic [6:0]  c_opc, c_f7;
    logic [2:0]  c_f3;
    logic [4:0]  c_rd, c_rs1, c_rs2;
    logic [1:0]  c_cnt;

    cg_rvarch_decode_stage #(.XLEN(32), .CNT_WIDTH(16)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin), .o_ready(a_ready),
        .i_instr(instr), .i_pc(pc[31:0]), .i_flush(flush),
        .o_valid(a_valid), .i_ready(rdy), .o_pc(a_pc),
        .o_opcode(a_opc), .o_funct3(a_f3), .o_funct7(a_f7),
        .o_rd(a_rd), .o_rs1(a_rs1), .o_rs2(a_rs2), .o_imm(a_imm),
        .o_rd_we(a_rd_we), .o_is_branch(a_br), .o_is_load(a_ld),
        .o_is_store(a_st), .o_is_jump(a_jmp), .o_is_word(a_word),
        .o_illegal(a_ill), .o_illegal_cnt(a_cnt)
    );

    cg_rvarch_decode_stage #(.XLEN(64), .CNT_WIDTH(16)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin), .o_ready(b_ready),
        .i_instr(instr), .i_pc(pc), .i_flush(flush),
        .o_valid(b_valid), .i_ready(rdy), .o_pc(b_pc),
        .o_opcode(b_opc), .o_funct3(b_f3), .o_funct7(b_f7),
        .o_rd(b_rd), .o_rs1(b_rs1), .o_rs2(b_rs2), .o_imm(b_imm),
        .o_rd_we(b_rd_we), .o_is_branch(b_br), .o_is_load(b_ld),
        .o_is_store(b_st), .o_is_jump(b_jmp), .o_is_word(b_word),
        .o_illegal(b_ill), .o_illegal_cnt(b_cnt)
    );

    cg_rvarch_decode_stage #(.XLEN(32), .CNT_WIDTH(2)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin), .o_ready(c_ready),
        .i_instr(instr), .i_pc(pc[31:0]), .i_flush(flush),
        .o_valid(c_valid), .i_ready(rdy), .o_pc(c_pc),
        .o_opcode(c_opc), .o_funct3(c_f3), .o_funct7(c_f7),
        .o_rd(c_rd), .o_rs1(c_rs1), .o_rs2(c_rs2), .o_imm(c_imm),
        .o_rd_we(c_rd_we), .o_is_branch(c_br), .o_is_load(c_ld),
        .o_is_store(c_st), .o_is_jump(c_jmp), .o_is_word(c_word),
        .o_illegal(c_ill), .o_illegal_cnt(c_cnt)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  flags;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm;
        bit          ill32;
        bit          ill64;
        bit          we32;
        bit          we64;
        bit          word64;
    } vec_t;

    int   ntests = 0;
    int   nfail  = 0;
    bit   mval;
    exp_t m32, m64;
    int   ca, cb, cc;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Decode written straight from the ISA rules using signed arithmetic.
    function automatic exp_t ref_dec(logic [31:0] ins, logic [63:0] p, bit rv64);
        exp_t        e;
        longint      s, imm;
        logic [6:0]  op;
        logic [2:0]  f;
        bit          ill, dst, wd;
        s  = longint'($signed(ins));
        op = ins[6:0];
        f  = ins[14:12];
        e.pc  = rv64 ? p : {32'h0, p[31:0]};
        e.opc = op;
        e.f3  = f;
        e.f7  = ins[31:25];
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        if (op inside {7'h03, 7'h13, 7'h1B, 7'h67})
            imm = s >>> 20;
        else if (op == 7'h23)
            imm = ((s >>> 25) << 5) + longint'(ins[11:7]);
        else if (op == 7'h63)
            imm = ((s >>> 31) << 12) + longint'(ins[7]) * 2048 +
                  longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        else if (op == 7'h6F)
            imm = ((s >>> 31) << 20) + longint'(ins[19:12]) * 4096 +
                  longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        else if (op inside {7'h37, 7'h17})
            imm = (s >>> 12) << 12;
        else
            imm = 0;
        ill = !((op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                            7'h63, 7'h67, 7'h6F, 7'h73}) ||
                (rv64 && op inside {7'h1B, 7'h3B}));
        if (ins[1:0] != 2'b11) ill = 1;
        if (op == 7'h03 && (f == 7 || (!rv64 && (f == 3 || f == 6)))) ill = 1;
        if (op == 7'h23 && (f >= 4 || (!rv64 && f == 3))) ill = 1;
        if (op == 7'h63 && (f == 2 || f == 3)) ill = 1;
        if (op == 7'h67 && f != 0) ill = 1;
        dst = (op inside {7'h03, 7'h13, 7'h17, 7'h33, 7'h37, 7'h6F, 7'h67}) ||
              (rv64 && op inside {7'h1B, 7'h3B});
        wd  = rv64 && (op inside {7'h1B, 7'h3B});
        e.flags = {dst && ins[11:7] != 0 && !ill, op == 7'h63 && !ill,
                   op == 7'h03 && !ill, op == 7'h23 && !ill,
                   (op == 7'h6F || op == 7'h67) && !ill, wd, ill};
        e.imm = rv64 ? imm : {32'h0, imm[31:0]};
        return e;
    endfunction

    task automatic model_reset();
        mval = 0;
        m32  = '{default: '0};
        m64  = '{default: '0};
        ca = 0; cb = 0; cc = 0;
    endtask

    task automatic model_step();
        bit   acc;
        exp_t e32, e64;
        if (!rst_n) begin
            model_reset();
        end else begin
            acc = vin && (!mval || rdy) && !flush;
            if (flush) mval = 0;
            else if (acc) mval = 1;
            else if (rdy) mval = 0;
            if (acc) begin
                e32 = ref_dec(instr, pc, 0);
                e64 = ref_dec(instr, pc, 1);
                m32 = e32;
                m64 = e64;
                if (e32.flags[0]) begin
                    if (ca < 65535) ca++;
                    if (cc < 3) cc++;
                end
                if (e64.flags[0] && cb < 65535) cb++;
            end
        end
    endtask

    task automatic chk_inst(input string p, input logic v, input logic [63:0] pcv,
                            input logic [63:0] imm, input logic [6:0] opc,
                            input logic [6:0] f7, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [6:0] fl,
                            input logic [63:0] cnt, input exp_t e, input int ec);
        chk({p, "_valid"}, 64'(v), 64'(mval));
        chk({p, "_pc"}, pcv, e.pc);
        chk({p, "_imm"}, imm, e.imm);
        chk({p, "_opcode"}, 64'(opc), 64'(e.opc));
        chk({p, "_funct7"}, 64'(f7), 64'(e.f7));
        chk({p, "_funct3"}, 64'(f3), 64'(e.f3));
        chk({p, "_regs"}, 64'({rd, rs1, rs2}), 64'({e.rd, e.rs1, e.rs2}));
        chk({p, "_flags"}, 64'(fl), 64'(e.flags));
        chk({p, "_cnt"}, cnt, 64'(ec));
    endtask

    task automatic chk_all();
        chk_inst("a", a_valid, 64'(a_pc), 64'(a_imm), a_opc, a_f7, a_f3,
                 a_rd, a_rs1, a_rs2,
                 {a_rd_we, a_br, a_ld, a_st, a_jmp, a_word, a_ill},
                 64'(a_cnt), m32, ca);
        chk_inst("b", b_valid, b_pc, b_imm, b_opc, b_f7, b_f3,
                 b_rd, b_rs1, b_rs2,
                 {b_rd_we, b_br, b_ld, b_st, b_jmp, b_word, b_ill},
                 64'(b_cnt), m64, cb);
        chk_inst("c", c_valid, 64'(c_pc), 64'(c_imm), c_opc, c_f7, c_f3,
                 c_rd, c_rs1, c_rs2,
                 {c_rd_we, c_br, c_ld, c_st, c_jmp, c_word, c_ill},
                 64'(c_cnt), m32, cc);
    endtask

    task automatic chk_ready();
        chk("ready", 64'({a_ready, b_ready, c_ready}),
            64'({3{!mval || rdy}}));
    endtask

    task automatic cyc();
        #1;
        chk_ready();
        @(posedge clk);
        model_step();
        #1;
        chk_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    vec_t        tv[14];
    logic [6:0]  ops[13];
    logic [63:0] pc_pool;
    int          cnt_before;

    initial begin
        tv[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 1, 0};
        tv[1]  = '{32'h123452B7, 64'h0000_0000_1234_5000, 0, 0, 1, 1, 0};
        tv[2]  = '{32'h0010009B, 64'h1,                   1, 0, 0, 1, 1};
        tv[3]  = '{32'h00000000, 64'h0,                   1, 1, 0, 0, 0};
        tv[4]  = '{32'h00112423, 64'h8,                   0, 0, 0, 0, 0};
        tv[5]  = '{32'h00113423, 64'h8,                   1, 0, 0, 0, 0};
        tv[6]  = '{32'h00013083, 64'h0,                   1, 0, 0, 1, 0};
        tv[7]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0};
        tv[8]  = '{32'h008000EF, 64'h8,                   0, 0, 1, 1, 0};
        tv[9]  = '{32'h000090E7, 64'h0,                   1, 1, 0, 0, 0};
        tv[10] = '{32'hFFFFF017, 64'hFFFF_FFFF_FFFF_F000, 0, 0, 0, 0, 0};
        tv[11] = '{32'h00004501, 64'h0,                   1, 1, 0, 0, 0};
        tv[12] = '{32'h00000073, 64'h0,                   0, 0, 0, 0, 0};
        tv[13] = '{32'h0000E083, 64'h0,                   1, 0, 0, 1, 0};
        ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

        rst_n = 0; vin = 0; flush = 0; rdy = 1; instr = '0; pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_ready();
        chk_all();

        // Release reset and accept on the very next edge.
        rst_n = 1;
        for (int i = 0; i < 14; i++) begin
            vin   = 1;
            instr = tv[i].ins;
            pc    = 64'h8000_0000_0000_1000 + 64'(i * 4);
            cyc();
            chk("tv_valid", 64'(a_valid), 64'h1);
            chk("tv_imm32", 64'(a_imm), {32'h0, tv[i].imm[31:0]});
            chk("tv_imm64", b_imm, tv[i].imm);
            chk("tv_ill32", 64'(a_ill), 64'(tv[i].ill32));
            chk("tv_ill64", 64'(b_ill), 64'(tv[i].ill64));
            chk("tv_we32", 64'(a_rd_we), 64'(tv[i].we32));
            chk("tv_we64", 64'(b_rd_we), 64'(tv[i].we64));
            chk("tv_word64", 64'(b_word), 64'(tv[i].word64));
            if (i == 2) chk("tv_cnt_first", 64'(a_cnt), 64'd1);
            if (i == 3) chk("tv_cnt_second", 64'(a_cnt), 64'd2);
            vin = 0;
            cyc();
            chk("tv_drain", 64'(a_valid), 64'h0);
        end
        chk("cnt_a_after_table", 64'(a_cnt), 64'd7);
        chk("cnt_c_saturated", 64'(c_cnt), 64'd3);

        // Downstream stall with upstream pressure, then back-to-back.
        vin = 1; rdy = 1; instr = 32'hFFF00093; pc = 64'h100;
        cyc();
        rdy = 0; instr = 32'h123452B7; pc = 64'h104;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_ready", 64'(a_ready), 64'h0);
            chk("stall_rd", 64'(a_rd), 64'd1);
            chk("stall_imm", 64'(a_imm), 64'hFFFF_FFFF);
        end
        rdy = 1;
        #1;
        chk("b2b_ready", 64'(a_ready), 64'h1);
        cyc();
        chk("b2b_valid", 64'(a_valid), 64'h1);
        chk("b2b_rd", 64'(a_rd), 64'd5);
        chk("b2b_imm64", b_imm, 64'h0000_0000_1234_5000);

        // Flush beats a pending accept of an illegal instruction.
        cnt_before = ca;
        rdy = 0; vin = 1; flush = 1; instr = 32'h0;
        cyc();
        chk("flush_valid", 64'(a_valid), 64'h0);
        chk("flush_cnt", 64'(a_cnt), 64'(cnt_before));
        flush = 0;

        // Asynchronous reset while holding an entry.
        instr = 32'h008000EF; pc = 64'h200;
        cyc();
        chk("pre_rst_valid", 64'(a_valid), 64'h1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_async_valid", 64'({a_valid, b_valid, c_valid}), 64'h0);
        chk("rst_async_imm", b_imm, 64'h0);
        chk_ready();
        chk_all();
        cyc();
        rst_n = 1;

        for (int n = 0; n < 400; n++) begin
            vin   = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 11) == 0);
            instr = $urandom;
            if ($urandom_range(0, 9) < 7)
                instr[6:0] = ops[$urandom_range(0, 12)];
            pc_pool = {$urandom, $urandom};
            pc = pc_pool;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
